// File: rtl/otter_id_ex_reg.sv
// OTTER ID/EX pipeline register: WB->ID capture bypass, load-use stall/bubble, EX operand forwarding; 1-cycle latency.
// STALL holds PC and IF/ID for one cycle per load-use pair; define OTTER_STALL_CNT_EN to enable the STALL_COUNT counter.
module otter_id_ex_reg #(
  parameter int ALU_FUN_W = 4,
  parameter int XLEN      = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ID_VALID,
  input  logic [XLEN-1:0]      ID_PC,
  input  logic [4:0]           ID_RS1_ADR,
  input  logic [4:0]           ID_RS2_ADR,
  input  logic [4:0]           ID_RD_ADR,
  input  logic                 ID_USES_RS1,
  input  logic                 ID_USES_RS2,
  input  logic [XLEN-1:0]      ID_RS1_DATA,
  input  logic [XLEN-1:0]      ID_RS2_DATA,
  input  logic [XLEN-1:0]      ID_IMM,
  input  logic                 ID_RF_WE,
  input  logic                 ID_MEM_RD,
  input  logic                 ID_MEM_WE,
  input  logic [ALU_FUN_W-1:0] ID_ALU_FUN,
  input  logic [4:0]           MEM_RD_ADR,
  input  logic                 MEM_RF_WE,
  input  logic                 MEM_MEM_RD,
  input  logic [XLEN-1:0]      MEM_FWD_DATA,
  input  logic [4:0]           WB_RD_ADR,
  input  logic                 WB_RF_WE,
  input  logic [XLEN-1:0]      WB_DATA,
  input  logic                 FLUSH,
  output logic                 STALL,
  output logic                 EX_VALID,
  output logic [XLEN-1:0]      EX_PC,
  output logic [XLEN-1:0]      EX_IMM,
  output logic [4:0]           EX_RS1_ADR,
  output logic [4:0]           EX_RS2_ADR,
  output logic [4:0]           EX_RD_ADR,
  output logic                 EX_RF_WE,
  output logic                 EX_MEM_RD,
  output logic                 EX_MEM_WE,
  output logic [ALU_FUN_W-1:0] EX_ALU_FUN,
  output logic [XLEN-1:0]      EX_RS1,
  output logic [XLEN-1:0]      EX_RS2,
  output logic [31:0]          STALL_COUNT
);

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic [4:0]           rs1_adr;
    logic [4:0]           rs2_adr;
    logic [4:0]           rd_adr;
    logic                 rf_we;
    logic                 mem_rd;
    logic                 mem_we;
    logic [ALU_FUN_W-1:0] alu_fun;
  } ex_t;

  ex_t  ex_q;
  ex_t  ex_d;
  logic hz;
  logic wb_cap_rs1;
  logic wb_cap_rs2;
  logic mem_fwd_rs1;
  logic mem_fwd_rs2;
  logic wb_fwd_rs1;
  logic wb_fwd_rs2;

  // The load result is only available from MEM/WB, so the consumer must wait one cycle.
  assign hz = ID_VALID && ex_q.valid && ex_q.mem_rd && (ex_q.rd_adr != 5'd0) &&
              ((ID_USES_RS1 && (ID_RS1_ADR == ex_q.rd_adr)) ||
               (ID_USES_RS2 && (ID_RS2_ADR == ex_q.rd_adr)));
  assign STALL = hz && !FLUSH;

  // The register file has no write-through, so the WB write is bypassed here.
  assign wb_cap_rs1 = WB_RF_WE && (WB_RD_ADR != 5'd0) && (WB_RD_ADR == ID_RS1_ADR);
  assign wb_cap_rs2 = WB_RF_WE && (WB_RD_ADR != 5'd0) && (WB_RD_ADR == ID_RS2_ADR);

  always_comb begin
    ex_d = '0;
    if (!FLUSH && !STALL) begin
      ex_d.valid   = ID_VALID;
      ex_d.pc      = ID_PC;
      ex_d.imm     = ID_IMM;
      ex_d.rs1     = wb_cap_rs1 ? WB_DATA : ID_RS1_DATA;
      ex_d.rs2     = wb_cap_rs2 ? WB_DATA : ID_RS2_DATA;
      ex_d.rs1_adr = ID_RS1_ADR;
      ex_d.rs2_adr = ID_RS2_ADR;
      ex_d.rd_adr  = ID_RD_ADR;
      ex_d.rf_we   = ID_VALID && ID_RF_WE;
      ex_d.mem_rd  = ID_VALID && ID_MEM_RD;
      ex_d.mem_we  = ID_VALID && ID_MEM_WE;
      ex_d.alu_fun = ID_ALU_FUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // A load in EX/MEM has no data yet; its value is picked up from MEM/WB instead.
  assign mem_fwd_rs1 = MEM_RF_WE && !MEM_MEM_RD && (MEM_RD_ADR != 5'd0) && (MEM_RD_ADR == ex_q.rs1_adr);
  assign mem_fwd_rs2 = MEM_RF_WE && !MEM_MEM_RD && (MEM_RD_ADR != 5'd0) && (MEM_RD_ADR == ex_q.rs2_adr);
  assign wb_fwd_rs1  = WB_RF_WE && (WB_RD_ADR != 5'd0) && (WB_RD_ADR == ex_q.rs1_adr);
  assign wb_fwd_rs2  = WB_RF_WE && (WB_RD_ADR != 5'd0) && (WB_RD_ADR == ex_q.rs2_adr);

  assign EX_RS1 = mem_fwd_rs1 ? MEM_FWD_DATA : (wb_fwd_rs1 ? WB_DATA : ex_q.rs1);
  assign EX_RS2 = mem_fwd_rs2 ? MEM_FWD_DATA : (wb_fwd_rs2 ? WB_DATA : ex_q.rs2);

  assign EX_VALID   = ex_q.valid;
  assign EX_PC      = ex_q.pc;
  assign EX_IMM     = ex_q.imm;
  assign EX_RS1_ADR = ex_q.rs1_adr;
  assign EX_RS2_ADR = ex_q.rs2_adr;
  assign EX_RD_ADR  = ex_q.rd_adr;
  assign EX_RF_WE   = ex_q.rf_we;
  assign EX_MEM_RD  = ex_q.mem_rd;
  assign EX_MEM_WE  = ex_q.mem_we;
  assign EX_ALU_FUN = ex_q.alu_fun;

`ifdef OTTER_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (STALL) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign STALL_COUNT = stall_cnt;
`else
  assign STALL_COUNT = '0;
`endif

endmodule
